// File: rtl/vga_glyph_render_pkg.sv
// Shared types and constants for the text-mode glyph renderer.
package vga_pkg;

    localparam int DEF_FONT_W  = 12;
    localparam int DEF_FONT_H  = 16;
    localparam int DEF_COLOR_W = 12;

    localparam int ATTR_INVERSE = 0;
    localparam int ATTR_BLINK   = 1;

    typedef enum logic [1:0] {
        CUR_OFF       = 2'd0,
        CUR_UNDERLINE = 2'd1,
        CUR_BLOCK     = 2'd2,
        CUR_BAR       = 2'd3
    } cursor_mode_t;

endpackage

// File: rtl/vga_glyph_render_if.sv
// Per-pixel character stream into the renderer and the pixel stream out of it.
import vga_pkg::*;

interface vga_glyph_render_if #(
    parameter int FONT_H  = DEF_FONT_H,
    parameter int COLOR_W = DEF_COLOR_W
);
    localparam int V_W = $clog2(FONT_H);

    logic               c_valid;
    logic [7:0]         char;
    logic [3:0]         h_font;
    logic [V_W-1:0]     v_font;
    logic [1:0]         attr;
    logic [COLOR_W-1:0] frontcolor;
    logic [COLOR_W-1:0] backcolor;
    logic               cursor;
    logic [1:0]         cursor_mode;
    logic               frame_tick;
    logic [COLOR_W-1:0] vga_data;
    logic               data_valid;

    modport master (
        output c_valid, char, h_font, v_font, attr, frontcolor, backcolor,
               cursor, cursor_mode, frame_tick,
        input  vga_data, data_valid
    );

    modport slave (
        input  c_valid, char, h_font, v_font, attr, frontcolor, backcolor,
               cursor, cursor_mode, frame_tick,
        output vga_data, data_valid
    );

endinterface

// File: rtl/vga_glyph_render_font_rom.sv
// Synchronous-read font ROM; the output register carries no reset.
module font_rom #(
    parameter int    WIDTH = 12,
    parameter int    DEPTH = 4096,
    parameter string FILE  = ""
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [WIDTH-1:0]         data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        data <= mem[addr];
    end

endmodule

// File: rtl/vga_glyph_render.sv
// Two-stage character pixel renderer: font lookup, then attribute/cursor/colour.
module vga_glyph_render
    import vga_pkg::*;
#(
    parameter int    FONT_W       = DEF_FONT_W,
    parameter int    FONT_H       = DEF_FONT_H,
    parameter int    COLOR_W      = DEF_COLOR_W,
    parameter int    BLINK_FRAMES = 30,
    parameter string FONT_FILE    = "font.txt"
) (
    input logic               pclk,
    input logic               rst,
    vga_glyph_render_if.slave pix
);

    localparam int V_W   = $clog2(FONT_H);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FONT_W-1:0]  rom_line;
    logic               s1_valid;
    logic [3:0]         s1_h;
    logic [V_W-1:0]     s1_v;
    logic [1:0]         s1_attr;
    logic [COLOR_W-1:0] s1_fg;
    logic [COLOR_W-1:0] s1_bg;
    logic               s1_cursor;
    cursor_mode_t       s1_mode;

    logic [CNT_W-1:0]   blink_cnt;
    logic               blink_phase;

    logic [FONT_W-1:0]  line_sh;
    logic               px;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
    logic [COLOR_W-1:0] pix_next;

    font_rom #(
        .WIDTH (FONT_W),
        .DEPTH (256 * FONT_H),
        .FILE  (FONT_FILE)
    ) u_rom (
        .clk  (pclk),
        .addr ({pix.char, pix.v_font}),
        .data (rom_line)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_h      <= '0;
            s1_v      <= '0;
            s1_attr   <= '0;
            s1_fg     <= '0;
            s1_bg     <= '0;
            s1_cursor <= 1'b0;
            s1_mode   <= CUR_OFF;
        end else begin
            s1_valid  <= pix.c_valid;
            s1_h      <= pix.h_font;
            s1_v      <= pix.v_font;
            s1_attr   <= pix.attr;
            s1_fg     <= pix.frontcolor;
            s1_bg     <= pix.backcolor;
            s1_cursor <= pix.cursor;
            s1_mode   <= cursor_mode_t'(pix.cursor_mode);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (pix.frame_tick) begin
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end
    end

    // Shifting left by the column brings the wanted pixel to the MSB; columns
    // past the glyph width are forced blank rather than wrapping.
    always_comb begin
        line_sh = rom_line << s1_h;
        px      = (int'(s1_h) < FONT_W) ? line_sh[FONT_W-1] : 1'b0;

        if (s1_attr[ATTR_BLINK] && blink_phase) px = 1'b0;

        if (s1_cursor && !blink_phase) begin
            case (s1_mode)
                CUR_UNDERLINE: if (s1_v == V_W'(FONT_H - 1)) px = 1'b1;
                CUR_BAR:       if (s1_h == 4'd0) px = 1'b1;
                CUR_BLOCK:     px = ~px;
                default:       ;
            endcase
        end

        fg       = s1_attr[ATTR_INVERSE] ? s1_bg : s1_fg;
        bg       = s1_attr[ATTR_INVERSE] ? s1_fg : s1_bg;
        pix_next = !s1_valid ? s1_bg : (px ? fg : bg);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            pix.vga_data   <= '0;
            pix.data_valid <= 1'b0;
        end else begin
            pix.vga_data   <= pix_next;
            pix.data_valid <= s1_valid;
        end
    end

endmodule

// File: tb/tb_vga_glyph_render.sv
// Scoreboard bench for vga_glyph_render with a locally generated font image.
module tb_vga_glyph_render;
    import vga_pkg::*;

    typedef struct {
        logic [11:0] d;
        logic        v;
        string       tag;
    } exp_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    vga_glyph_render_if #(.FONT_H(16), .COLOR_W(12)) pix ();

    vga_glyph_render #(
        .FONT_W       (12),
        .FONT_H       (16),
        .COLOR_W      (12),
        .BLINK_FRAMES (2),
        .FONT_FILE    ("")
    ) u_dut (
        .pclk (pclk),
        .rst  (rst),
        .pix  (pix)
    );

    logic [11:0] font_model [4096];
    exp_t        q [$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          m_cnt  = 0;
    logic        m_ph   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic cv, input logic [7:0] ch, input logic [3:0] h,
                                   input logic [3:0] v, input logic [1:0] at,
                                   input logic [11:0] fgc, input logic [11:0] bgc,
                                   input logic cur, input logic [1:0] cm, input logic ph);
        exp_t        e;
        logic [11:0] line;
        logic        b;
        e.tag = "";
        if (!cv) begin
            e.d = bgc;
            e.v = 1'b0;
            return e;
        end
        line = font_model[{ch, v}];
        b    = (h < 4'd12) ? line[4'd11 - h] : 1'b0;
        if (at[1] && ph) b = 1'b0;
        if (cur && !ph) begin
            if (cm == 2'd1 && v == 4'd15) b = 1'b1;
            if (cm == 2'd3 && h == 4'd0)  b = 1'b1;
            if (cm == 2'd2)               b = ~b;
        end
        if (at[0]) e.d = b ? bgc : fgc;
        else       e.d = b ? fgc : bgc;
        e.v = 1'b1;
        return e;
    endfunction

    task automatic cyc(input logic cv, input logic [7:0] ch, input logic [3:0] h,
                       input logic [3:0] v, input logic [1:0] at,
                       input logic [11:0] fgc, input logic [11:0] bgc,
                       input logic cur, input logic [1:0] cm,
                       input logic tick, input logic r, input string tag);
        exp_t e;
        @(negedge pclk);
        if (q.size() == 2) begin
            e = q.pop_front();
            chk({e.tag, "/data"},  32'(pix.vga_data),   32'(e.d));
            chk({e.tag, "/valid"}, 32'(pix.data_valid), 32'(e.v));
        end
        rst             = r;
        pix.c_valid     = cv;
        pix.char        = ch;
        pix.h_font      = h;
        pix.v_font      = v;
        pix.attr        = at;
        pix.frontcolor  = fgc;
        pix.backcolor   = bgc;
        pix.cursor      = cur;
        pix.cursor_mode = cm;
        pix.frame_tick  = tick;
        if (r) begin
            m_cnt = 0;
            m_ph  = 1'b0;
            q.delete();
            e.d   = 12'h000;
            e.v   = 1'b0;
            e.tag = {tag, "+1"};
            q.push_back(e);
            e.tag = {tag, "+2"};
            q.push_back(e);
        end else begin
            if (tick) begin
                if (m_cnt == 1) begin
                    m_cnt = 0;
                    m_ph  = ~m_ph;
                end else begin
                    m_cnt++;
                end
            end
            e     = model(cv, ch, h, v, at, fgc, bgc, cur, cm, m_ph);
            e.tag = tag;
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic tick, input string tag);
        cyc(1'b0, 8'h00, 4'd0, 4'd0, 2'b00, 12'h000, 12'h000, 1'b0, 2'd0, tick, 1'b0, tag);
    endtask

    initial begin
        logic [11:0] w;
        logic [1:0]  modes [4];
        logic [3:0]  hs [3];
        logic [3:0]  vs [3];
        modes = '{2'd1, 2'd3, 2'd2, 2'd0};
        hs    = '{4'd0, 4'd5, 4'd15};
        vs    = '{4'd0, 4'd7, 4'd15};

        // The font image is written straight into the ROM array and mirrored here.
        for (int c = 0; c < 256; c++) begin
            for (int r = 0; r < 16; r++) begin
                w = 12'((c * 37 + r * 113) ^ (c << 4));
                if (c == 8'h20) w = 12'h000;
                if (c == 8'hFF) w = 12'hFFF;
                if (c == 8'h41 && r == 5) w = 12'hF0F;
                font_model[c*16 + r]       = w;
                u_dut.u_rom.mem[c*16 + r]  = w;
            end
        end

        pix.c_valid = 1'b0; pix.char = 8'h00; pix.h_font = 4'd0; pix.v_font = 4'd0;
        pix.attr = 2'b00; pix.frontcolor = 12'h000; pix.backcolor = 12'h000;
        pix.cursor = 1'b0; pix.cursor_mode = 2'd0; pix.frame_tick = 1'b0;

        repeat (3) cyc(1'b0, 8'h00, 4'd0, 4'd0, 2'b00, 12'h000, 12'h555, 1'b0, 2'd0, 1'b1, 1'b1, "rst");

        for (int h = 0; h < 16; h++)
            cyc(1'b1, 8'h41, 4'(h), 4'd5, 2'b00, 12'hFFF, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0,
                $sformatf("glyphA_h%0d", h));
        for (int h = 0; h < 12; h++)
            cyc(1'b1, 8'h41, 4'(h), 4'd5, 2'b01, 12'hFFF, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0,
                $sformatf("inverse_h%0d", h));
        repeat (3)
            cyc(1'b0, 8'h41, 4'd0, 4'd5, 2'b01, 12'hFFF, 12'h00F, 1'b0, 2'd0, 1'b0, 1'b0, "cvalid0");

        foreach (modes[m])
            foreach (vs[i])
                foreach (hs[j])
                    cyc(1'b1, 8'h20, hs[j], vs[i], 2'b00, 12'hABC, 12'h123, 1'b1, modes[m], 1'b0, 1'b0,
                        $sformatf("cur_m%0d_v%0d_h%0d", modes[m], vs[i], hs[j]));

        for (int p = 0; p < 3; p++) begin
            cyc(1'b1, 8'hFF, 4'd3,  4'd3, 2'b10, 12'hFFF, 12'h000, 1'b1, 2'd2, 1'b0, 1'b0, $sformatf("blink%0d_h3", p));
            cyc(1'b1, 8'hFF, 4'd12, 4'd3, 2'b10, 12'hFFF, 12'h000, 1'b1, 2'd2, 1'b0, 1'b0, $sformatf("blink%0d_h12", p));
            cyc(1'b1, 8'hFF, 4'd6,  4'd3, 2'b10, 12'hFFF, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0, $sformatf("blink%0d_attr", p));
            idle(1'b1, "tick");
            idle(1'b1, "tick");
        end

        idle(1'b1, "pre_rst_tick");
        for (int h = 0; h < 4; h++)
            cyc(1'b1, 8'h41, 4'(h), 4'd5, 2'b00, 12'hFFF, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0,
                $sformatf("pre_rst_h%0d", h));
        cyc(1'b1, 8'h41, 4'd4, 4'd5, 2'b00, 12'hFFF, 12'h000, 1'b0, 2'd0, 1'b1, 1'b1, "midrst");
        for (int h = 5; h < 9; h++)
            cyc(1'b1, 8'h41, 4'(h), 4'd5, 2'b00, 12'hFFF, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0,
                $sformatf("post_rst_h%0d", h));
        idle(1'b1, "post_rst_tick1");
        cyc(1'b1, 8'hFF, 4'd6, 4'd3, 2'b10, 12'hFFF, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0, "cnt_cleared_visible");
        idle(1'b1, "post_rst_tick2");
        cyc(1'b1, 8'hFF, 4'd6, 4'd3, 2'b10, 12'hFFF, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0, "cnt_cleared_blank");

        idle(1'b0, "drain");
        idle(1'b0, "drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
